fir_cfg_master: RTL and testbench

AXI4-Lite initiator that issues single-beat configuration writes and reads toward the FIR block's AXI4-Lite slave port, e.g. tap coefficients at 0x040–0x06C and ap_start/ap_done/ap_idle at 0x000. A local command/response port drives it: one command in, one response out, no overlap. Includes a per-transaction timeout so that a non-responding slave cannot hang the issuer.

---
 rtl/fir_cfg_master_if.sv | 33 +++
 rtl/fir_cfg_master.sv | 188 ++++++++++++++++++
 tb/tb_fir_cfg_master.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_cfg_master_if.sv
// AXI4-Lite channel bundle between the configuration master and the FIR
// slave port; write completion is the AW+W handshake pair, so there is no B channel.
interface fir_cfg_master_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) ();
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   awvalid;
    logic                   awready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   wvalid;
    logic                   wready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   arvalid;
    logic                   arready;
    logic [pDATA_WIDTH-1:0] rdata;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata,  wvalid,  input wready,
        output araddr, arvalid, input arready,
        input  rdata,  rvalid,  output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata,  wvalid,  output wready,
        input  araddr, arvalid, output arready,
        output rdata,  rvalid,  input rready
    );
endinterface

// File: rtl/fir_cfg_master.sv
// Single-beat AXI4-Lite configuration initiator driven by a one-in/one-out
// command/response port, with a per-transaction timeout abort.
module fir_cfg_master #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTIMEOUT    = 64
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [pADDR_WIDTH-1:0] cmd_addr,
    input  logic [pDATA_WIDTH-1:0] cmd_wdata,
    output logic                   rsp_valid,
    output logic                   rsp_err,
    output logic [pDATA_WIDTH-1:0] rsp_rdata,
    output logic                   busy,
    fir_cfg_master_if.master       axil
);
    localparam int CNT_W = $clog2(pTIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(pTIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WR, RD_A, RD_D, RESP} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                   awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                   arvalid_q, arvalid_d, rready_q, rready_d;
    logic [pADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [pDATA_WIDTH-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic                   cmd_ready_q, busy_q;
    logic                   aw_hs, w_hs, ar_hs, r_hs, aw_ok, w_ok, expired;

    assign aw_hs   = awvalid_q & axil.awready;
    assign w_hs    = wvalid_q  & axil.wready;
    assign ar_hs   = arvalid_q & axil.arready;
    assign r_hs    = rready_q  & axil.rvalid;
    assign aw_ok   = aw_done_q | aw_hs;
    assign w_ok    = w_done_q  | w_hs;
    assign expired = (cnt_q == CNT_LAST);

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
        end
    end

    // A handshake landing on the expiry edge wins over the abort, so every
    // completion test comes before the expiry test.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cnt_d = '0;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_A;
                    end
                end
            end
            WR: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                aw_done_d = aw_ok;
                w_done_d  = w_ok;
                if (aw_ok && w_ok) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else if (expired) begin
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_A: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = RD_D;
                end else if (expired) begin
                    arvalid_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_D: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = axil.rdata;
                    state_d     = RESP;
                end else if (expired) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready    = cmd_ready_q;
    assign busy         = busy_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign axil.awaddr  = awaddr_q;
    assign axil.awvalid = awvalid_q;
    assign axil.wdata   = wdata_q;
    assign axil.wvalid  = wvalid_q;
    assign axil.araddr  = araddr_q;
    assign axil.arvalid = arvalid_q;
    assign axil.rready  = rready_q;
endmodule

// File: tb/tb_fir_cfg_master.sv
// Bench for fir_cfg_master: delay-programmable AXI-Lite slave, a latency/outcome
// model derived from the handshake timing rules, directed table plus random traffic.
module tb_fir_cfg_master;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          axis_clk   = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic          cmd_valid  = 1'b0;
    logic          cmd_write  = 1'b0;
    logic [AW-1:0] cmd_addr   = '0;
    logic [DW-1:0] cmd_wdata  = '0;
    logic          cmd_ready, rsp_valid, rsp_err, busy;
    logic [DW-1:0] rsp_rdata;

    fir_cfg_master_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) axil ();

    fir_cfg_master #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pTIMEOUT(TO)) dut (
        .axis_clk  (axis_clk),
        .axis_rst_n(axis_rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .axil      (axil)
    );

    always #5 axis_clk = ~axis_clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cycle = 0;
    always @(posedge axis_clk) cycle <= cycle + 1;

    // Slave behaviour: each ready rises once its valid has been high for d cycles.
    int unsigned   s_da = 0, s_dw = 0, s_dar = 0, s_dr = 0;
    logic [DW-1:0] s_rdata = '0;
    int unsigned   aw_age = 0, w_age = 0, ar_age = 0, r_age = 0;
    int unsigned   aw_hs = 0, w_hs = 0, ar_hs = 0, r_hs = 0;
    int unsigned   aw_hi = 0, w_hi = 0, ar_hi = 0, r_hi = 0;
    int unsigned   stab_viol = 0, overlap = 0, rsp_pulses = 0;
    logic          aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
    logic [AW-1:0] got_awaddr = '0, got_araddr = '0, last_awaddr = '0, last_araddr = '0;
    logic [DW-1:0] got_wdata = '0, last_wdata = '0;

    always @(negedge axis_clk) begin
        if (axil.awvalid) begin
            if (aw_pend && axil.awaddr !== last_awaddr) stab_viol++;
            aw_hi++;
            axil.awready = (aw_age == s_da);
            aw_age++;
            if (axil.awready) begin aw_hs++; got_awaddr = axil.awaddr; end
            aw_pend = !axil.awready;
            last_awaddr = axil.awaddr;
        end else begin
            axil.awready = 1'b0; aw_age = 0; aw_pend = 1'b0;
        end
        if (axil.wvalid) begin
            if (w_pend && axil.wdata !== last_wdata) stab_viol++;
            w_hi++;
            axil.wready = (w_age == s_dw);
            w_age++;
            if (axil.wready) begin w_hs++; got_wdata = axil.wdata; end
            w_pend = !axil.wready;
            last_wdata = axil.wdata;
        end else begin
            axil.wready = 1'b0; w_age = 0; w_pend = 1'b0;
        end
        if (axil.arvalid) begin
            if (ar_pend && axil.araddr !== last_araddr) stab_viol++;
            ar_hi++;
            axil.arready = (ar_age == s_dar);
            ar_age++;
            if (axil.arready) begin ar_hs++; got_araddr = axil.araddr; end
            ar_pend = !axil.arready;
            last_araddr = axil.araddr;
        end else begin
            axil.arready = 1'b0; ar_age = 0; ar_pend = 1'b0;
        end
        if (axil.rready) begin
            r_hi++;
            axil.rvalid = (r_age >= s_dr);
            axil.rdata  = axil.rvalid ? s_rdata : ~s_rdata;
            if (axil.rvalid) r_hs++;
            r_age++;
        end else begin
            axil.rvalid = 1'b0; axil.rdata = '0; r_age = 0;
        end
        if (rsp_valid) begin
            rsp_pulses++;
            if (cmd_ready) overlap++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int unsigned mn(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    // A channel with stall d handshakes on valid cycle d+1; it must fit within TO cycles.
    function automatic void model(input bit wr, input int unsigned da, dw, dar, dr,
                                  input logic [DW-1:0] sd, output int unsigned lat,
                                  output bit err, output logic [DW-1:0] rd,
                                  output int unsigned e_awhi, e_whi, e_arhi, e_rhi,
                                  output int unsigned e_awhs, e_whs, e_arhs, e_rhs);
        int unsigned m;
        e_awhi = 0; e_whi = 0; e_arhi = 0; e_rhi = 0;
        e_awhs = 0; e_whs = 0; e_arhs = 0; e_rhs = 0;
        rd = '0;
        if (wr) begin
            e_awhi = mn(da + 1, TO); e_whi = mn(dw + 1, TO);
            e_awhs = (da + 1 <= TO) ? 1 : 0; e_whs = (dw + 1 <= TO) ? 1 : 0;
            m = (da > dw) ? da : dw;
            if (m + 1 <= TO) begin lat = m + 2; err = 1'b0; end
            else begin lat = TO + 1; err = 1'b1; end
        end else begin
            e_arhi = mn(dar + 1, TO);
            if (dar + 1 > TO) begin
                lat = TO + 1; err = 1'b1;
            end else begin
                e_arhs = 1; e_rhi = mn(dr + 1, TO);
                if (dr + 1 > TO) begin lat = dar + 1 + TO + 1; err = 1'b1; end
                else begin lat = dar + dr + 3; err = 1'b0; e_rhs = 1; rd = sd; end
            end
        end
    endfunction

    task automatic run_txn(input string tag, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input int unsigned da, dw, dar, dr,
                           input logic [DW-1:0] sd, input int unsigned exp_lat,
                           input bit exp_err, input logic [DW-1:0] exp_rdata,
                           output int unsigned acc_cycle);
        int unsigned ml, k, lat;
        bit me;
        logic [DW-1:0] mr;
        int unsigned e_awhi, e_whi, e_arhi, e_rhi, e_awhs, e_whs, e_arhs, e_rhs;
        int unsigned b_awhi, b_whi, b_arhi, b_rhi, b_awhs, b_whs, b_arhs, b_rhs;
        model(wr, da, dw, dar, dr, sd, ml, me, mr,
              e_awhi, e_whi, e_arhi, e_rhi, e_awhs, e_whs, e_arhs, e_rhs);
        k = 0;
        while (!cmd_ready && k < 50) begin @(negedge axis_clk); k++; end
        if (!cmd_ready) chk({tag, " cmd_ready wait"}, 32'(cmd_ready), 32'd1);
        s_da = da; s_dw = dw; s_dar = dar; s_dr = dr; s_rdata = sd;
        b_awhi = aw_hi; b_whi = w_hi; b_arhi = ar_hi; b_rhi = r_hi;
        b_awhs = aw_hs; b_whs = w_hs; b_arhs = ar_hs; b_rhs = r_hs;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
        @(posedge axis_clk);
        acc_cycle = cycle;
        #1 cmd_valid = 1'b0;
        lat = 0; k = 0;
        while (lat == 0 && k < 40) begin
            @(negedge axis_clk); k++;
            if (rsp_valid) lat = k;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, " rsp_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, " cmd_ready during rsp"}, 32'(cmd_ready), 32'd0);
        #1;
        if (wr) begin
            chk({tag, " awvalid cycles"}, aw_hi - b_awhi, e_awhi);
            chk({tag, " wvalid cycles"}, w_hi - b_whi, e_whi);
            chk({tag, " aw handshakes"}, aw_hs - b_awhs, e_awhs);
            chk({tag, " w handshakes"}, w_hs - b_whs, e_whs);
            if (e_awhs != 0) chk({tag, " awaddr"}, 32'(got_awaddr), 32'(addr));
            if (e_whs != 0) chk({tag, " wdata"}, got_wdata, wd);
        end else begin
            chk({tag, " arvalid cycles"}, ar_hi - b_arhi, e_arhi);
            chk({tag, " rready cycles"}, r_hi - b_rhi, e_rhi);
            chk({tag, " ar handshakes"}, ar_hs - b_arhs, e_arhs);
            chk({tag, " r handshakes"}, r_hs - b_rhs, e_rhs);
            if (e_arhs != 0) chk({tag, " araddr"}, 32'(got_araddr), 32'(addr));
        end
        @(negedge axis_clk);
        chk({tag, " rsp one pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, " cmd_ready back"}, 32'(cmd_ready), 32'd1);
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int unsigned   da, dw, dar, dr;
        logic [DW-1:0] sdata;
        int unsigned   exp_lat;
        bit            exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    initial begin
        vec_t          tbl[10];
        int            taps[11];
        int unsigned   acc, prev_acc, pulses0, ml, dummy;
        int unsigned   rda, rdw, rdar, rdr;
        logic [DW-1:0] v, rwd, rsd, mr;
        logic [AW-1:0] raddr;
        bit            rwr, me;
        int unsigned   d1, d2, d3, d4, d5, d6, d7, d8;

        //           wr  addr    wdata          da dw dar  dr   sdata          lat err rdata
        tbl[0] = '{1'b1, 12'h040, 32'h0,         2, 0, 0,   0,   32'h0,         4, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 12'h000, 32'h0,         0, 0, 0,   3,   32'h4,         6, 1'b0, 32'h4};
        tbl[2] = '{1'b0, 12'h010, 32'h0,         0, 0, 255, 0,   32'hDEAD,      9, 1'b1, 32'h0};
        tbl[3] = '{1'b1, 12'h044, 32'h1234_5678, 0, 0, 0,   0,   32'h0,         2, 1'b0, 32'h0};
        tbl[4] = '{1'b1, 12'h048, 32'hA5A5_0001, 3, 0, 0,   0,   32'h0,         5, 1'b0, 32'h0};
        tbl[5] = '{1'b1, 12'h04C, 32'h0000_00FF, 0, 2, 0,   0,   32'h0,         4, 1'b0, 32'h0};
        tbl[6] = '{1'b1, 12'h050, 32'h1,         8, 0, 0,   0,   32'h0,         9, 1'b1, 32'h0};
        tbl[7] = '{1'b0, 12'h014, 32'h0,         0, 0, 2,   255, 32'hBEEF,      12, 1'b1, 32'h0};
        tbl[8] = '{1'b0, 12'h018, 32'h0,         0, 0, 7,   0,   32'hCAFE_0018, 10, 1'b0, 32'hCAFE_0018};
        tbl[9] = '{1'b1, 12'h01C, 32'h77,        7, 7, 0,   0,   32'h0,         9, 1'b0, 32'h0};
        taps = '{-10, -5, -9, 23, 56, 63, 56, 23, -9, -5, -10};

        repeat (3) @(negedge axis_clk);
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset valids", {28'd0, axil.awvalid, axil.wvalid, axil.arvalid, axil.rready}, 32'd0);
        chk("reset awaddr", 32'(axil.awaddr), 32'd0);
        chk("reset wdata", axil.wdata, 32'd0);
        chk("reset araddr", 32'(axil.araddr), 32'd0);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);

        for (int i = 0; i < 10; i++)
            run_txn($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                    tbl[i].da, tbl[i].dw, tbl[i].dar, tbl[i].dr, tbl[i].sdata,
                    tbl[i].exp_lat, tbl[i].exp_err, tbl[i].exp_rdata, acc);

        prev_acc = 0;
        for (int i = 0; i < 11; i++) begin
            v = taps[i];
            run_txn($sformatf("tap%0d", i), 1'b1, 12'(12'h040 + 4 * i), v,
                    0, 0, 0, 0, 32'h0, 2, 1'b0, 32'h0, acc);
            if (i > 0) chk($sformatf("tap%0d cmd interval", i), acc - prev_acc, 32'd3);
            prev_acc = acc;
        end

        // Reset while the read data phase is stalled.
        s_dar = 0; s_dr = 1000;
        cmd_write = 1'b0; cmd_addr = 12'h020; cmd_valid = 1'b1;
        @(posedge axis_clk);
        #1 cmd_valid = 1'b0;
        @(negedge axis_clk);
        chk("rst seq arvalid", 32'(axil.arvalid), 32'd1);
        @(negedge axis_clk);
        chk("rst seq rready", 32'(axil.rready), 32'd1);
        @(negedge axis_clk);
        #1 pulses0 = rsp_pulses;
        #1 axis_rst_n = 1'b0;
        #1;
        chk("rst seq arvalid low", 32'(axil.arvalid), 32'd0);
        chk("rst seq rready low", 32'(axil.rready), 32'd0);
        chk("rst seq busy low", 32'(busy), 32'd0);
        chk("rst seq cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(negedge axis_clk);
        axis_rst_n = 1'b1;
        repeat (3) @(negedge axis_clk);
        #1;
        chk("rst seq no rsp", rsp_pulses, pulses0);
        chk("rst seq idle ready", 32'(cmd_ready), 32'd1);
        s_dr = 0;
        run_txn("post rst read", 1'b0, 12'h000, 32'h0, 0, 0, 0, 1, 32'h0000_0005,
                4, 1'b0, 32'h5, acc);

        for (int i = 0; i < 40; i++) begin
            rwr = 1'($urandom_range(0, 1));
            raddr = 12'($urandom) & 12'hFFC;
            rwd = $urandom; rsd = $urandom;
            rda = $urandom_range(0, 9); rdw = $urandom_range(0, 9);
            rdar = $urandom_range(0, 9); rdr = $urandom_range(0, 9);
            model(rwr, rda, rdw, rdar, rdr, rsd, ml, me, mr, d1, d2, d3, d4, d5, d6, d7, d8);
            run_txn($sformatf("rnd%0d", i), rwr, raddr, rwd, rda, rdw, rdar, rdr, rsd,
                    ml, me, mr, dummy);
        end

        chk("addr/data stability", stab_viol, 32'd0);
        chk("rsp_valid with cmd_ready", overlap, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end
endmodule
